// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants for the stream demultiplexer.
// Holds the default channel count and data width used as parameter defaults,
// and the width and saturation value of the optional out-of-range counter.
package stream_demux_pkg;

  // Default parameter values for stream_demux.
  localparam int DEF_N_OUT = 3;
  localparam int DEF_W     = 8;

  // Out-of-range select counter: width and saturation value.
  localparam int                 ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/demux_slot.sv
// demux_slot: single-entry output register for one demux channel.
// Ports: clk/rst (sync, active-high); i_load/i_data load a new beat;
//        i_drain_rdy is the consumer's ready; o_valid/o_data are the held beat;
//        o_free tells the parent the slot can take a beat this cycle.
// Latency 1 cycle from load to o_valid. A load in the same cycle as a drain
// replaces the beat without a bubble, so the channel sustains one beat per cycle.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_drain_rdy,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Free when empty, or when the current beat leaves this cycle. This is the
  // only path from down_ready to up_ready, and it never looks at up_valid.
  assign o_free  = !r_valid || i_drain_rdy;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // A load wins over a drain, so simultaneous load and drain keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_drain_rdy) begin
      r_valid <= 1'b0;
    end
  end

  // Data only moves on a load, so it is stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready upstream to one of N_OUT registered outputs.
// Ports: clk/rst (sync, active-high); up_valid/up_ready/up_sel/up_data upstream;
//        down_valid/down_ready per channel; down_data flattened (channel i at [i*W +: W]);
//        err_cnt (only with STREAM_DEMUX_ERR_CNT_EN) counts dropped out-of-range beats.
// Latency 1 cycle. A stalled channel only blocks beats addressed to it; out-of-range
// selects are always accepted and discarded.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int W     = DEF_W,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [SEL_W-1:0]     up_sel,
  input  logic [W-1:0]         up_data,
  output logic [N_OUT-1:0]     down_valid,
  input  logic [N_OUT-1:0]     down_ready,
  output logic [N_OUT*W-1:0]   down_data
`ifdef STREAM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic [N_OUT-1:0] w_hit;      // one-hot decode of up_sel, all zero when out of range
  logic [N_OUT-1:0] w_free;     // per-slot "can accept this cycle"
  logic [N_OUT-1:0] w_load;     // per-slot load strobe
  logic             w_sel_ok;   // up_sel addresses an existing channel
  logic             w_up_ready;
  logic             w_drop;     // accepted out-of-range beat

  // Decode by comparing against each channel index. A select that matches
  // nothing is out of range, which handles N_OUT values that are not a power
  // of two without a separate magnitude compare.
  always_comb begin
    w_hit      = '0;
    w_sel_ok   = 1'b0;
    w_up_ready = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      if (up_sel == SEL_W'(i)) begin
        w_hit[i]   = 1'b1;
        w_sel_ok   = 1'b1;
        w_up_ready = w_free[i];
      end
    end
  end

  assign up_ready = w_up_ready;
  assign w_load   = w_hit & w_free & {N_OUT{up_valid}};
  assign w_drop   = up_valid && !w_sel_ok;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    logic [W-1:0] w_slot_data;

    demux_slot #(
      .W (W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load[g]),
      .i_data      (up_data),
      .i_drain_rdy (down_ready[g]),
      .o_valid     (down_valid[g]),
      .o_data      (w_slot_data),
      .o_free      (w_free[g])
    );

    assign down_data[g*W +: W] = w_slot_data;
  end

`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of discarded beats; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_drop && (r_err_cnt != ERR_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  // Out-of-range beats are still accepted (up_ready stays high); nothing records them.
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int N = 3;
  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [SW-1:0] up_sel;
  logic [DW-1:0] up_data;
  logic [N-1:0]  down_valid;
  logic [N-1:0]  down_ready;
  logic [N*DW-1:0] down_data;
`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  always #5 clk = ~clk;

  stream_demux #(.N_OUT(N), .W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_sel     (up_sel),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef STREAM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a one-deep mailbox. A beat addressed to a
  // channel goes in if the mailbox is empty or being emptied this cycle; a full
  // mailbox empties when its consumer is ready. Bad addresses are counted.
  bit        m_full [N];
  bit [7:0]  m_data [N];
  int        m_err;
  bit        m_started = 0;

  function automatic bit model_up_ready();
    if (int'(up_sel) >= N) return 1'b1;
    return !m_full[up_sel] || down_ready[up_sel];
  endfunction

  always @(posedge clk) begin
    bit accept;
    accept = up_valid && model_up_ready();
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_full[c] = 0;
        m_data[c] = 8'h00;
      end
      m_err = 0;
    end else begin
      for (int c = 0; c < N; c++)
        if (m_full[c] && down_ready[c]) m_full[c] = 0;
      if (accept) begin
        if (int'(up_sel) < N) begin
          m_full[up_sel] = 1;
          m_data[up_sel] = up_data;
        end else if (m_err < 255) begin
          m_err = m_err + 1;
        end
      end
    end
    m_started = 1;
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      for (int c = 0; c < N; c++) begin
        chk($sformatf("cyc_valid%0d", c), 32'(down_valid[c]), 32'(m_full[c]));
        chk($sformatf("cyc_data%0d", c), 32'(down_data[c*DW +: DW]), 32'(m_data[c]));
      end
      chk("cyc_up_ready", 32'(up_ready), 32'(model_up_ready()));
`ifdef STREAM_DEMUX_ERR_CNT_EN
      chk("cyc_err_cnt", 32'(err_cnt), 32'(m_err));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [7:0] d);
    up_valid = v;
    up_sel   = s;
    up_data  = d;
    #1;
  endtask

  function automatic logic [7:0] slice(input int c);
    return down_data[c*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    down_ready = 3'b000;
    drive(1'b1, 2'd0, 8'hFF);

    // Reset with up_valid high: nothing loads.
    tick();
    chk("rst_valid_c1", 32'(down_valid), 32'h0);
    tick();
    chk("rst_valid_c2", 32'(down_valid), 32'h0);
    chk("rst_data", 32'(down_data), 32'h0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("rst_err", 32'(err_cnt), 32'h0);
`endif
    rst = 1'b0;

    // Routing at full rate across channels.
    down_ready = 3'b111;
    drive(1'b1, 2'd0, 8'hA0);
    chk("route_rdy0", 32'(up_ready), 32'h1);
    tick();
    chk("route_v0", 32'(down_valid), 32'b001);
    chk("route_d0", 32'(slice(0)), 32'hA0);
    drive(1'b1, 2'd1, 8'hA1);
    chk("route_rdy1", 32'(up_ready), 32'h1);
    tick();
    chk("route_v1", 32'(down_valid), 32'b010);
    chk("route_d1", 32'(slice(1)), 32'hA1);
    drive(1'b1, 2'd2, 8'hA2);
    chk("route_rdy2", 32'(up_ready), 32'h1);
    tick();
    chk("route_v2", 32'(down_valid), 32'b100);
    chk("route_d2", 32'(slice(2)), 32'hA2);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("route_idle", 32'(down_valid), 32'b000);

    // Backpressure isolation on channel 1.
    down_ready = 3'b101;
    drive(1'b1, 2'd1, 8'h11);
    tick();
    chk("bp_v_first", 32'(down_valid), 32'b010);
    chk("bp_d_first", 32'(slice(1)), 32'h11);
    drive(1'b1, 2'd1, 8'h22);
    chk("bp_blocked", 32'(up_ready), 32'h0);
    tick();
    tick();
    chk("bp_hold_d", 32'(slice(1)), 32'h11);
    chk("bp_hold_v", 32'(down_valid), 32'b010);
    drive(1'b1, 2'd0, 8'h33);
    chk("bp_other_rdy", 32'(up_ready), 32'h1);
    tick();
    chk("bp_other_v", 32'(down_valid), 32'b011);
    chk("bp_other_d0", 32'(slice(0)), 32'h33);
    chk("bp_other_d1", 32'(slice(1)), 32'h11);
    down_ready = 3'b111;
    drive(1'b1, 2'd1, 8'h22);
    chk("bp_release_rdy", 32'(up_ready), 32'h1);
    tick();
    chk("bp_release_v", 32'(down_valid), 32'b010);
    chk("bp_release_d", 32'(slice(1)), 32'h22);
    drive(1'b0, 2'd0, 8'h00);
    tick();

    // Ten back-to-back beats into channel 2, each visible on the next cycle.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'd2, 8'(k));
      chk($sformatf("fr_rdy%0d", k), 32'(up_ready), 32'h1);
      tick();
      chk($sformatf("fr_v%0d", k), 32'(down_valid[2]), 32'h1);
      chk($sformatf("fr_d%0d", k), 32'(slice(2)), 32'(k));
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("fr_drained", 32'(down_valid), 32'b000);

    // Out-of-range select with channel 0 stalled full.
    down_ready = 3'b000;
    drive(1'b1, 2'd0, 8'h5A);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd3, 8'hEE);
      chk($sformatf("oor_rdy%0d", k), 32'(up_ready), 32'h1);
      tick();
    end
    chk("oor_v", 32'(down_valid), 32'b001);
    chk("oor_d0", 32'(slice(0)), 32'h5A);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("oor_err5", 32'(err_cnt), 32'd5);
`endif
    for (int k = 0; k < 300; k++) tick();
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("oor_err_sat", 32'(err_cnt), 32'd255);
`endif
    chk("oor_v_after", 32'(down_valid), 32'b001);

    // Fill the other two slots, then reset mid-operation.
    drive(1'b1, 2'd1, 8'hB1);
    tick();
    drive(1'b1, 2'd2, 8'hB2);
    tick();
    chk("mid_full", 32'(down_valid), 32'b111);
    drive(1'b1, 2'd0, 8'hC0);
    chk("mid_stall_rdy", 32'(up_ready), 32'h0);
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("mid_rst_v", 32'(down_valid), 32'b000);
    chk("mid_rst_d", 32'(down_data), 32'h0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
`endif
    rst = 1'b0;
    drive(1'b1, 2'd1, 8'hC1);
    chk("post_rst_rdy", 32'(up_ready), 32'h1);
    tick();
    chk("post_rst_v", 32'(down_valid), 32'b010);
    chk("post_rst_d", 32'(slice(1)), 32'hC1);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
